fetch_pipe_stage: RTL and testbench
===================================

Name: fetch_pipe_stage

Overview:
- PC register, instruction-fetch sequencing and IF/ID pipeline register for the 5-stage 16-bit CPU. Sits directly upstream of the decode-stage hazard unit.
- Consumes its load-use stall and branch-rs dependency signals; produces the IF/ID instruction fields that unit compares.
- Owns the 2-cycle branch-register stall counter, the branch-redirect flush and the halt freeze.

Parameters:
- WIDTH, 16, datapath/PC/instruction width.
- RESET_PC, 16'h0000, PC value after reset.
- NOP_INSTR, 16'h0800, bubble instruction loaded into IF/ID on flush/halt.
- HALT_OP, 4'h0, opcode field (instr[15:12]) identifying HALT.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_data  in  WIDTH  instruction at pc_addr (combinational imem read, same cycle)
- pc_addr  out  WIDTH  current PC to instruction memory
- stall_sig  in  1  load-use stall from hazard unit (single-cycle request)
- rs_dep  in  1  load-to-branch-rs dependency from hazard unit
- fd_is_br_reg  in  1  decode: IF/ID instruction is a register-indirect branch/jump using rs
- br_taken  in  1  decode: branch/jump in ID resolved taken
- br_target  in  WIDTH  redirect address, valid with br_taken
- fd_instr  out  WIDTH  IF/ID instruction
- fd_pc_plus2  out  WIDTH  IF/ID PC+2
- fd_valid  out  1  IF/ID holds a real instruction
- stall_active  out  1  fetch/IF-ID frozen this cycle; decode injects bubble into ID/EX
- halted  out  1  HALT latched, fetch frozen

Behaviour:
- Reset: pc_addr=RESET_PC, fd_instr=NOP_INSTR, fd_pc_plus2=0, fd_valid=0, halted=0, branch-stall counter=0. Reset mid-stall/halt aborts all state identically.
- States: FETCH, HALTED. Branch-stall counter bst_cnt is 1 bit, orthogonal to the states.
- br_stall_req = rs_dep & fd_is_br_reg & fd_valid.
- stall_active (combinational) = stall_sig | br_stall_req | (bst_cnt==1).
- Branch-rs stall is exactly 2 cycles:
  - Cycle N: br_stall_req & bst_cnt==0 → stall, bst_cnt<=1.
  - Cycle N+1: bst_cnt==1 → stall regardless of inputs, bst_cnt<=0.
  - N+2: re-triggers only if br_stall_req is high again.
- Priority per cycle: rst > stall_active > br_taken > halt detect > normal.
- Stall: pc_addr and the entire IF/ID register hold. br_taken is ignored, because the branch operands are not ready.
- Flush (br_taken & !stall_active):
  - pc_addr<=br_target; fd_instr<=NOP_INSTR, fd_valid<=0, fd_pc_plus2<=0.
  - In HALTED: go to FETCH, halted<=0. This cancels a speculatively fetched HALT.
- Normal (FETCH, no stall, no flush):
  - fd_instr<=imem_data, fd_pc_plus2<=pc_addr+2, fd_valid<=1.
  - pc_addr<=pc_addr+2, modulo 2^WIDTH (16'hFFFE wraps to 16'h0000).
- Halt detect (FETCH, no stall, no flush, imem_data[15:12]==HALT_OP):
  - HALT is latched into IF/ID as a normal fetch.
  - pc_addr holds (not incremented); go to HALTED, halted<=1 next cycle.
- HALTED, no flush:
  - pc_addr holds; fd_instr<=NOP_INSTR, fd_valid<=0. stall_active still follows its equation.
  - Held instructions continue to drain downstream; only rst or br_taken leaves HALTED.
- Latency: instruction fetched in cycle N appears on fd_* in N+1. Redirect takes effect on pc_addr in N+1, and the target instruction appears on fd_* in N+2.
- stall_sig and br_stall_req in the same cycle: a single stall, and the counter still loads. The total is 2 cycles, not 3.

Test Plan:
- Sequential fetch:
  - Stimulus: reset, then imem returns 16'h1111, 16'h2222, 16'h3333 at PC 0, 2, 4.
  - Response: fd_instr matches one cycle later, fd_pc_plus2=2, 4, 6, fd_valid=1 from cycle 2.
- Load-use stall:
  - Stimulus: stall_sig=1 for one cycle at PC=16'h0006.
  - Response: pc_addr stays 6 and fd_* unchanged for 1 cycle, stall_active=1, then PC resumes to 8.
- Branch-rs stall:
  - Stimulus: fd_valid=1, fd_is_br_reg=1, rs_dep=1 for one cycle only.
  - Response: stall_active=1 for exactly 2 cycles, PC frozen both, then normal fetch.
- Redirect:
  - Stimulus: br_taken=1, br_target=16'h0040 at PC=16'h000A.
  - Response: next cycle pc_addr=16'h0040, fd_instr=NOP_INSTR, fd_valid=0.
  - Stimulus: same, but with stall_sig=1 simultaneously.
  - Response: redirect ignored, PC holds 16'h000A.
- Halt:
  - Stimulus: imem_data=16'h0000 at PC=16'h0010.
  - Response: HALT in IF/ID, halted=1, pc_addr stays 16'h0010, subsequent fd_valid=0.
  - Stimulus: then br_taken to 16'h0020.
  - Response: halted=0, pc_addr=16'h0020.
- Boundary:
  - Stimulus: PC=16'hFFFE with a non-halt instruction.
  - Response: pc_addr wraps to 16'h0000, fd_pc_plus2=16'h0000.
  - Stimulus: rst asserted during the second branch-stall cycle.
  - Response: all outputs at reset values next cycle, bst_cnt=0.

Source files
------------

// File: rtl/fetch_pipe_stage.sv
// ---------------------------------------------------------------------------
// fetch_pipe_stage
//   PC register, instruction-fetch sequencing and IF/ID pipeline register for
//   the 5-stage 16-bit CPU. Owns the 2-cycle branch-register stall counter,
//   the branch-redirect flush and the HALT freeze.
//
// Ports
//   clk           system clock, all state on the rising edge
//   rst           synchronous active-high reset
//   imem_data     instruction at pc_addr (combinational imem read)
//   pc_addr       current PC to instruction memory
//   stall_sig     load-use stall request from the hazard unit
//   rs_dep        load-to-branch-rs dependency from the hazard unit
//   fd_is_br_reg  IF/ID instruction is a register-indirect branch/jump
//   br_taken      branch/jump in ID resolved taken
//   br_target     redirect address, valid with br_taken
//   fd_instr      IF/ID instruction
//   fd_pc_plus2   IF/ID PC+2
//   fd_valid      IF/ID holds a real instruction
//   stall_active  fetch and IF/ID frozen this cycle
//   halted        HALT latched, fetch frozen
// ---------------------------------------------------------------------------
module fetch_pipe_stage #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_PC  = 16'h0000,
   parameter logic [WIDTH-1:0] NOP_INSTR = 16'h0800,
   parameter logic [3:0]       HALT_OP   = 4'h0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] imem_data,
   output logic [WIDTH-1:0] pc_addr,
   input  logic             stall_sig,
   input  logic             rs_dep,
   input  logic             fd_is_br_reg,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   output logic [WIDTH-1:0] fd_instr,
   output logic [WIDTH-1:0] fd_pc_plus2,
   output logic             fd_valid,
   output logic             stall_active,
   output logic             halted
);

   typedef enum logic {
      FETCH  = 1'b0,
      HALTED = 1'b1
   } state_e;

   localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(2);

   state_e           state_q,    state_d;
   logic             bst_cnt_q,  bst_cnt_d;
   logic [WIDTH-1:0] pc_q,       pc_d;
   logic [WIDTH-1:0] instr_q,    instr_d;
   logic [WIDTH-1:0] pc_plus2_q, pc_plus2_d;
   logic             valid_q,    valid_d;

   logic             br_stall_req;
   logic             stall;
   logic [WIDTH-1:0] pc_inc;

   // A register-indirect branch whose rs is still being loaded must wait two
   // cycles; only a real instruction in IF/ID can raise the request.
   assign br_stall_req = rs_dep & fd_is_br_reg & valid_q;
   assign stall        = stall_sig | br_stall_req | bst_cnt_q;
   assign pc_inc       = pc_q + PC_STEP;   // wraps modulo 2^WIDTH

   // NOTE: every signal gets a default before any branch so no path leaves it
   // unassigned; that is what keeps this combinational block latch-free.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_plus2_d = pc_plus2_q;
      valid_d    = valid_q;

      // The second stall cycle is unconditional; a new request is only
      // accepted once the counter is back at zero, so overlapping stall_sig
      // and br_stall_req still totals two cycles.
      bst_cnt_d  = bst_cnt_q ? 1'b0 : br_stall_req;

      if (stall) begin
         // Hold everything; a taken branch is ignored because its operands
         // are not ready yet and decode will present it again.
      end else if (br_taken) begin
         pc_d       = br_target;
         instr_d    = NOP_INSTR;
         pc_plus2_d = '0;
         valid_d    = 1'b0;
         state_d    = FETCH;   // also cancels a speculatively fetched HALT
      end else if (state_q == FETCH) begin
         instr_d    = imem_data;
         pc_plus2_d = pc_inc;
         valid_d    = 1'b1;
         if (imem_data[WIDTH-1:WIDTH-4] == HALT_OP) begin
            state_d = HALTED;   // PC parks on the HALT
         end else begin
            pc_d    = pc_inc;
         end
      end else begin
         // HALTED: keep feeding bubbles while older instructions drain.
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end
   end

   // NOTE: non-blocking assignments in the clocked block so every register
   // samples the pre-edge values regardless of statement order. The IF/ID
   // contents are reset too, so decode never sees stale data as an instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH;
         bst_cnt_q  <= 1'b0;
         pc_q       <= RESET_PC;
         instr_q    <= NOP_INSTR;
         pc_plus2_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bst_cnt_q  <= bst_cnt_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc_plus2_q <= pc_plus2_d;
         valid_q    <= valid_d;
      end
   end

   assign pc_addr      = pc_q;
   assign fd_instr     = instr_q;
   assign fd_pc_plus2  = pc_plus2_q;
   assign fd_valid     = valid_q;
   assign stall_active = stall;
   assign halted       = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_pipe_stage
//   Directed bench for fetch_pipe_stage. The instruction memory is a small
//   lookup: fixed words at 0/2/4, an optional HALT at 0x0010, and
//   {4'h1, pc[11:0]} everywhere else so ordinary words never decode as HALT.
//   Inputs are driven 1 time unit after each rising edge; registered outputs
//   are sampled there, combinational stall_active after a further #1.
// ---------------------------------------------------------------------------
module tb_fetch_pipe_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] imem_data;
   logic [15:0] pc_addr;
   logic        stall_sig;
   logic        rs_dep;
   logic        fd_is_br_reg;
   logic        br_taken;
   logic [15:0] br_target;
   logic [15:0] fd_instr;
   logic [15:0] fd_pc_plus2;
   logic        fd_valid;
   logic        stall_active;
   logic        halted;

   logic        halt_en;
   int          vectors     = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   fetch_pipe_stage dut (
      .clk          (clk),
      .rst          (rst),
      .imem_data    (imem_data),
      .pc_addr      (pc_addr),
      .stall_sig    (stall_sig),
      .rs_dep       (rs_dep),
      .fd_is_br_reg (fd_is_br_reg),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .fd_instr     (fd_instr),
      .fd_pc_plus2  (fd_pc_plus2),
      .fd_valid     (fd_valid),
      .stall_active (stall_active),
      .halted       (halted)
   );

   always_comb begin
      case (pc_addr)
         16'h0000: imem_data = 16'h1111;
         16'h0002: imem_data = 16'h2222;
         16'h0004: imem_data = 16'h3333;
         16'h0010: imem_data = halt_en ? 16'h0000 : 16'h1010;
         default:  imem_data = {4'h1, pc_addr[11:0]};
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall_sig = 1'b0; rs_dep = 1'b0; fd_is_br_reg = 1'b0;
      br_taken = 1'b0; br_target = '0; halt_en = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      vectors++; if (pc_addr !== 16'h0000) begin miscompares++; $display("FAIL reset pc_addr: got %h want %h", pc_addr, 16'h0000); end
      vectors++; if (fd_instr !== 16'h0800) begin miscompares++; $display("FAIL reset fd_instr: got %h want %h", fd_instr, 16'h0800); end
      vectors++; if (fd_pc_plus2 !== 16'h0000) begin miscompares++; $display("FAIL reset fd_pc_plus2: got %h want %h", fd_pc_plus2, 16'h0000); end
      vectors++; if (fd_valid !== 1'b0) begin miscompares++; $display("FAIL reset fd_valid: got %b want 0", fd_valid); end
      vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset halted: got %b want 0", halted); end
      vectors++; if (stall_active !== 1'b0) begin miscompares++; $display("FAIL reset stall_active: got %b want 0", stall_active); end
   endtask

   task automatic test_sequential();
      logic [15:0] exp_i [3];
      exp_i[0] = 16'h1111; exp_i[1] = 16'h2222; exp_i[2] = 16'h3333;
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++; if (fd_instr !== exp_i[k]) begin miscompares++; $display("FAIL seq%0d fd_instr: got %h want %h", k, fd_instr, exp_i[k]); end
         vectors++; if (fd_pc_plus2 !== 16'(2*k+2)) begin miscompares++; $display("FAIL seq%0d fd_pc_plus2: got %h want %h", k, fd_pc_plus2, 16'(2*k+2)); end
         vectors++; if (fd_valid !== 1'b1) begin miscompares++; $display("FAIL seq%0d fd_valid: got %b want 1", k, fd_valid); end
         vectors++; if (pc_addr !== 16'(2*k+2)) begin miscompares++; $display("FAIL seq%0d pc_addr: got %h want %h", k, pc_addr, 16'(2*k+2)); end
      end
   endtask

   task automatic test_load_use();
      stall_sig = 1'b1;
      #1;
      vectors++; if (stall_active !== 1'b1) begin miscompares++; $display("FAIL load_use stall_active: got %b want 1", stall_active); end
      tick();
      stall_sig = 1'b0;
      #1;
      vectors++; if (pc_addr !== 16'h0006) begin miscompares++; $display("FAIL load_use pc hold: got %h want %h", pc_addr, 16'h0006); end
      vectors++; if (fd_instr !== 16'h3333 || fd_pc_plus2 !== 16'h0006) begin miscompares++; $display("FAIL load_use ifid hold: got %h/%h want 3333/0006", fd_instr, fd_pc_plus2); end
      vectors++; if (stall_active !== 1'b0) begin miscompares++; $display("FAIL load_use single cycle: got %b want 0", stall_active); end
      tick();
      vectors++; if (pc_addr !== 16'h0008 || fd_instr !== 16'h1006) begin miscompares++; $display("FAIL load_use resume: got pc %h instr %h want 0008/1006", pc_addr, fd_instr); end
   endtask

   task automatic test_br_stall();
      fd_is_br_reg = 1'b1; rs_dep = 1'b1;
      #1;
      vectors++; if (stall_active !== 1'b1) begin miscompares++; $display("FAIL br_stall cycle1: got %b want 1", stall_active); end
      tick();
      fd_is_br_reg = 1'b0; rs_dep = 1'b0;
      #1;
      vectors++; if (stall_active !== 1'b1 || pc_addr !== 16'h0008) begin miscompares++; $display("FAIL br_stall cycle2: got stall %b pc %h want 1/0008", stall_active, pc_addr); end
      tick();
      vectors++; if (stall_active !== 1'b0 || pc_addr !== 16'h0008 || fd_instr !== 16'h1006) begin miscompares++; $display("FAIL br_stall end: got stall %b pc %h instr %h want 0/0008/1006", stall_active, pc_addr, fd_instr); end
      tick();
      vectors++; if (pc_addr !== 16'h000A || fd_instr !== 16'h1008 || fd_pc_plus2 !== 16'h000A) begin miscompares++; $display("FAIL br_stall resume: got pc %h instr %h pc2 %h want 000A/1008/000A", pc_addr, fd_instr, fd_pc_plus2); end
   endtask

   task automatic test_redirect();
      stall_sig = 1'b1; br_taken = 1'b1; br_target = 16'h0040;
      tick();
      vectors++; if (pc_addr !== 16'h000A || fd_instr !== 16'h1008) begin miscompares++; $display("FAIL redirect_stalled: got pc %h instr %h want 000A/1008", pc_addr, fd_instr); end
      stall_sig = 1'b0;
      tick();
      br_taken = 1'b0;
      vectors++; if (pc_addr !== 16'h0040) begin miscompares++; $display("FAIL redirect pc: got %h want 0040", pc_addr); end
      vectors++; if (fd_instr !== 16'h0800 || fd_valid !== 1'b0 || fd_pc_plus2 !== 16'h0000) begin miscompares++; $display("FAIL redirect flush: got %h/%b/%h want 0800/0/0000", fd_instr, fd_valid, fd_pc_plus2); end
      tick();
      vectors++; if (fd_instr !== 16'h1040 || fd_pc_plus2 !== 16'h0042 || fd_valid !== 1'b1) begin miscompares++; $display("FAIL redirect target: got %h/%h/%b want 1040/0042/1", fd_instr, fd_pc_plus2, fd_valid); end
   endtask

   task automatic test_halt();
      br_taken = 1'b1; br_target = 16'h0010;
      tick();
      br_taken = 1'b0; halt_en = 1'b1;
      tick();
      vectors++; if (fd_instr !== 16'h0000 || fd_valid !== 1'b1 || fd_pc_plus2 !== 16'h0012) begin miscompares++; $display("FAIL halt latch: got %h/%b/%h want 0000/1/0012", fd_instr, fd_valid, fd_pc_plus2); end
      vectors++; if (halted !== 1'b1 || pc_addr !== 16'h0010) begin miscompares++; $display("FAIL halt state: got halted %b pc %h want 1/0010", halted, pc_addr); end
      tick();
      vectors++; if (halted !== 1'b1 || pc_addr !== 16'h0010 || fd_valid !== 1'b0 || fd_instr !== 16'h0800) begin miscompares++; $display("FAIL halt freeze: got %b/%h/%b/%h want 1/0010/0/0800", halted, pc_addr, fd_valid, fd_instr); end
      br_taken = 1'b1; br_target = 16'h0020;
      tick();
      br_taken = 1'b0; halt_en = 1'b0;
      vectors++; if (halted !== 1'b0 || pc_addr !== 16'h0020) begin miscompares++; $display("FAIL halt exit: got halted %b pc %h want 0/0020", halted, pc_addr); end
      tick();
      vectors++; if (fd_instr !== 16'h1020 || pc_addr !== 16'h0022) begin miscompares++; $display("FAIL halt refetch: got instr %h pc %h want 1020/0022", fd_instr, pc_addr); end
   endtask

   task automatic test_wrap();
      br_taken = 1'b1; br_target = 16'hFFFE;
      tick();
      br_taken = 1'b0;
      tick();
      vectors++; if (pc_addr !== 16'h0000 || fd_pc_plus2 !== 16'h0000) begin miscompares++; $display("FAIL wrap: got pc %h pc2 %h want 0000/0000", pc_addr, fd_pc_plus2); end
      vectors++; if (fd_instr !== 16'h1FFE || fd_valid !== 1'b1) begin miscompares++; $display("FAIL wrap instr: got %h/%b want 1FFE/1", fd_instr, fd_valid); end
   endtask

   task automatic test_back_to_back();
      // load-use and branch-rs stall in the same cycle: two stall cycles total
      stall_sig = 1'b1; fd_is_br_reg = 1'b1; rs_dep = 1'b1;
      tick();
      stall_sig = 1'b0; fd_is_br_reg = 1'b0; rs_dep = 1'b0;
      #1;
      vectors++; if (stall_active !== 1'b1 || pc_addr !== 16'h0000) begin miscompares++; $display("FAIL overlap cycle2: got stall %b pc %h want 1/0000", stall_active, pc_addr); end
      tick();
      vectors++; if (stall_active !== 1'b0 || pc_addr !== 16'h0000) begin miscompares++; $display("FAIL overlap end: got stall %b pc %h want 0/0000", stall_active, pc_addr); end
      tick();
      vectors++; if (pc_addr !== 16'h0002 || fd_instr !== 16'h1111) begin miscompares++; $display("FAIL overlap resume: got pc %h instr %h want 0002/1111", pc_addr, fd_instr); end
   endtask

   task automatic test_reset_mid_stall();
      fd_is_br_reg = 1'b1; rs_dep = 1'b1;
      tick();
      fd_is_br_reg = 1'b0; rs_dep = 1'b0;
      #1;
      vectors++; if (stall_active !== 1'b1) begin miscompares++; $display("FAIL rst_mid precondition: got %b want 1", stall_active); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      vectors++; if (pc_addr !== 16'h0000 || fd_instr !== 16'h0800 || fd_pc_plus2 !== 16'h0000 || fd_valid !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL rst_mid outputs: got %h/%h/%h/%b/%b want 0000/0800/0000/0/0", pc_addr, fd_instr, fd_pc_plus2, fd_valid, halted); end
      vectors++; if (stall_active !== 1'b0) begin miscompares++; $display("FAIL rst_mid bst_cnt: stall_active got %b want 0", stall_active); end
      tick();
      vectors++; if (pc_addr !== 16'h0002 || fd_instr !== 16'h1111) begin miscompares++; $display("FAIL rst_mid restart: got pc %h instr %h want 0002/1111", pc_addr, fd_instr); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_load_use();
      test_br_stall();
      test_redirect();
      test_halt();
      test_wrap();
      test_back_to_back();
      test_reset_mid_stall();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
